// File: rtl/frame_pattern_gen_pkg.sv
// Shared definitions for the LED frame pattern generator: pattern modes,
// palette indices, full-scale GRB words and default geometry.
package frame_pattern_gen_pkg;

  // Frame geometry and brightness defaults
  localparam int DEFAULT_NUM_LEDS     = 5;
  localparam int DEFAULT_BRIGHT_SHIFT = 3;
  localparam int GRB_W                = 24;

  // Pattern select encodings, sampled on each accepted step
  typedef enum logic [1:0] {
    MODE_STATIC = 2'b00,
    MODE_CHASE  = 2'b01,
    MODE_FILL   = 2'b10,
    MODE_BLINK  = 2'b11
  } mode_e;

  // Palette indices held per LED
  localparam logic [2:0] PAL_OFF     = 3'd0;
  localparam logic [2:0] PAL_RED     = 3'd1;
  localparam logic [2:0] PAL_GREEN   = 3'd2;
  localparam logic [2:0] PAL_BLUE    = 3'd3;
  localparam logic [2:0] PAL_YELLOW  = 3'd4;
  localparam logic [2:0] PAL_CYAN    = 3'd5;
  localparam logic [2:0] PAL_MAGENTA = 3'd6;
  localparam logic [2:0] PAL_WHITE   = 3'd7;

  // Full-scale colours packed as {G, R, B}
  localparam logic [23:0] GRB_OFF     = 24'h000000;
  localparam logic [23:0] GRB_RED     = 24'h00FF00;
  localparam logic [23:0] GRB_GREEN   = 24'hFF0000;
  localparam logic [23:0] GRB_BLUE    = 24'h0000FF;
  localparam logic [23:0] GRB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] GRB_CYAN    = 24'hFF00FF;
  localparam logic [23:0] GRB_MAGENTA = 24'h00FFFF;
  localparam logic [23:0] GRB_WHITE   = 24'hFFFFFF;

  // First fill colour after reset and after each fill wrap past white
  localparam logic [2:0] FILL_FIRST_COLOR = PAL_RED;

  // Full-scale GRB word for a palette index
  function automatic logic [23:0] palette_grb(input logic [2:0] idx);
    logic [23:0] word;
    case (idx)
      PAL_RED:     word = GRB_RED;
      PAL_GREEN:   word = GRB_GREEN;
      PAL_BLUE:    word = GRB_BLUE;
      PAL_YELLOW:  word = GRB_YELLOW;
      PAL_CYAN:    word = GRB_CYAN;
      PAL_MAGENTA: word = GRB_MAGENTA;
      PAL_WHITE:   word = GRB_WHITE;
      default:     word = GRB_OFF;
    endcase
    return word;
  endfunction

  // Next fill colour: cycles 1..7 and never lands on off
  function automatic logic [2:0] next_fill_color(input logic [2:0] color);
    return (color == PAL_WHITE) ? FILL_FIRST_COLOR : color + 3'd1;
  endfunction

endpackage

// File: rtl/frame_pattern_gen_grb_palette.sv
// Maps one LED's palette index to its dimmed 24-bit GRB word. Each channel
// is the full-scale value shifted right by BRIGHT_SHIFT, zero-filled.
module grb_palette
  import frame_pattern_gen_pkg::*;
#(
  parameter int BRIGHT_SHIFT = DEFAULT_BRIGHT_SHIFT
) (
  input  logic [2:0]  idx,
  output logic [23:0] grb
);

  logic [23:0] full;
  logic [7:0]  ch_g;
  logic [7:0]  ch_r;
  logic [7:0]  ch_b;

  // Look up the full-scale colour and dim each channel independently
  always_comb begin
    full = palette_grb(idx);
    ch_g = full[23:16] >> BRIGHT_SHIFT;
    ch_r = full[15:8]  >> BRIGHT_SHIFT;
    ch_b = full[7:0]   >> BRIGHT_SHIFT;
    grb  = {ch_g, ch_r, ch_b};
  end

endmodule

// File: rtl/frame_pattern_gen.sv
// LED frame pattern generator. Holds a palette index per LED, advances the
// pattern once per accepted step, and registers the resulting GRB frame one
// clock later.
//
// Handshake: Cycle is a one-clock pulse from the send controller. A step is
// accepted on any edge where Cycle=1 and Running=1 (Running as it was before
// any coincident Go toggle). The accepting edge updates the pattern and drops
// FrameValid; the first following edge without another step loads GRBSeq and
// raises FrameValid. GRBSeq never changes except on that loading edge, so a
// consumer may use it whenever FrameValid=1.
module frame_pattern_gen
  import frame_pattern_gen_pkg::*;
#(
  parameter int NUM_LEDS     = DEFAULT_NUM_LEDS,
  parameter int BRIGHT_SHIFT = DEFAULT_BRIGHT_SHIFT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      Go,
  input  logic                      Cycle,
  input  logic [1:0]                mode,
  output logic [GRB_W*NUM_LEDS-1:0] GRBSeq,
  output logic                      FrameValid,
  output logic [7:0]                StepCount,
  output logic                      Running
);

  localparam int POS_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam int FRAME_W = GRB_W * NUM_LEDS;

  // Go synchroniser and edge detector
  logic go_sync1;
  logic go_sync2;
  logic go_last;
  logic go_rise;

  // Pattern state
  logic [2:0]       idx [NUM_LEDS];
  logic [POS_W-1:0] fill_pos;
  logic [2:0]       fill_color;
  logic             blank;

  // Step decode and fill look-ahead
  logic             step;
  mode_e            step_mode;
  logic [POS_W-1:0] fill_pos_nxt;
  logic [2:0]       fill_color_nxt;

  // Frame build
  logic [23:0]        grb_word [NUM_LEDS];
  logic [FRAME_W-1:0] frame_next;
  logic               pending;

  // Bring the asynchronous Go button into the clock domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      go_sync1 <= 1'b0;
      go_sync2 <= 1'b0;
      go_last  <= 1'b0;
    end else begin
      go_sync1 <= Go;
      go_sync2 <= go_sync1;
      go_last  <= go_sync2;
    end
  end

  assign go_rise = go_sync2 & ~go_last;

  // Each Go press flips the run state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Running <= 1'b0;
    end else if (go_rise) begin
      Running <= ~Running;
    end
  end

  // Step uses the registered run state, so a coincident Go toggle only
  // affects later steps
  assign step      = Cycle & Running;
  assign step_mode = mode_e'(mode);

  // Position and colour a fill step would move to
  always_comb begin
    fill_pos_nxt   = fill_pos;
    fill_color_nxt = fill_color;
    if (fill_pos == POS_W'(NUM_LEDS - 1)) begin
      fill_pos_nxt   = '0;
      fill_color_nxt = next_fill_color(fill_color);
    end else begin
      fill_pos_nxt   = fill_pos + POS_W'(1);
    end
  end

  // Advance the pattern state on each accepted step
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        idx[i] <= 3'(i + 1);
      end
      fill_pos   <= '0;
      fill_color <= FILL_FIRST_COLOR;
      blank      <= 1'b0;
      StepCount  <= 8'd0;
    end else if (step) begin
      StepCount <= StepCount + 8'd1;
      blank     <= (step_mode == MODE_BLINK) ? ~blank : 1'b0;
      case (step_mode)
        MODE_CHASE: begin
          for (int i = 0; i < NUM_LEDS; i++) begin
            idx[i] <= idx[(i + 1) % NUM_LEDS];
          end
        end
        MODE_FILL: begin
          fill_pos   <= fill_pos_nxt;
          fill_color <= fill_color_nxt;
          for (int i = 0; i < NUM_LEDS; i++) begin
            idx[i] <= (i <= int'(fill_pos_nxt)) ? fill_color_nxt : PAL_OFF;
          end
        end
        default: begin
          // Static and blink keep the indices as they are
        end
      endcase
    end
  end

  // One dimmed colour word per LED
  for (genvar g = 0; g < NUM_LEDS; g++) begin : g_led
    grb_palette #(
      .BRIGHT_SHIFT(BRIGHT_SHIFT)
    ) u_palette (
      .idx(idx[g]),
      .grb(grb_word[g])
    );
  end

  // Pack LED0 into the most significant word; blank overrides all colours
  always_comb begin
    frame_next = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      frame_next[GRB_W*(NUM_LEDS-1-i) +: GRB_W] = blank ? GRB_OFF : grb_word[i];
    end
  end

  // Register the frame one edge after the last step of a burst
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      GRBSeq     <= '0;
      FrameValid <= 1'b0;
      pending    <= 1'b1;
    end else if (step) begin
      FrameValid <= 1'b0;
      pending    <= 1'b1;
    end else if (pending) begin
      GRBSeq     <= frame_next;
      FrameValid <= 1'b1;
      pending    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_pattern_gen.sv
// Bench for frame_pattern_gen: directed scenarios plus randomized step
// bursts, checked by a scoreboard fed from a colour-list reference model.
module tb_frame_pattern_gen;

  localparam int N     = 5;
  localparam int SHIFT = 3;
  localparam int FW    = 24 * N;
  localparam int W     = FW + 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          go;
  logic          cycle;
  logic [1:0]    mode;
  logic [FW-1:0] grbseq;
  logic          frame_valid;
  logic [7:0]    step_count;
  logic          running;

  frame_pattern_gen #(
    .NUM_LEDS(N),
    .BRIGHT_SHIFT(SHIFT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Go(go),
    .Cycle(cycle),
    .mode(mode),
    .GRBSeq(grbseq),
    .FrameValid(frame_valid),
    .StepCount(step_count),
    .Running(running)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int passed = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  // LED colours listed from LED0 upward, plus the pattern bookkeeping.
  int m_col[$];
  int m_fill_pos;
  int m_fill_color;
  bit m_blank;
  int m_count;
  bit m_running;

  function automatic void model_reset();
    m_col = {};
    for (int i = 0; i < N; i++) m_col.push_back(i + 1);
    m_fill_pos   = 0;
    m_fill_color = 1;
    m_blank      = 0;
    m_count      = 0;
    m_running    = 0;
  endfunction

  function automatic void model_step(input int md);
    int c;
    m_count = (m_count + 1) % 256;
    m_blank = (md == 3) ? !m_blank : 1'b0;
    if (md == 1) begin
      // everything slides one place toward LED0, LED0 wraps to the end
      c = m_col.pop_front();
      m_col.push_back(c);
    end else if (md == 2) begin
      m_fill_pos = (m_fill_pos + 1) % N;
      if (m_fill_pos == 0) m_fill_color = (m_fill_color % 7) + 1;
      for (int i = 0; i < N; i++) m_col[i] = (i <= m_fill_pos) ? m_fill_color : 0;
    end
  endfunction

  function automatic logic [FW-1:0] model_frame();
    logic [FW-1:0] f;
    logic [7:0] lvl, g, r, b;
    int c;
    f = '0;
    lvl = 8'(255 >> SHIFT);
    if (!m_blank) begin
      for (int i = 0; i < N; i++) begin
        c = m_col[i];
        g = (c == 2 || c == 4 || c == 5 || c == 7) ? lvl : 8'd0;
        r = (c == 1 || c == 4 || c == 6 || c == 7) ? lvl : 8'd0;
        b = (c == 3 || c == 5 || c == 6 || c == 7) ? lvl : 8'd0;
        f[FW-1-24*i -: 24] = {g, r, b};
      end
    end
    return f;
  endfunction

  function automatic logic [W-1:0] model_expect();
    return {model_frame(), 8'(m_count)};
  endfunction

  // ---------------- monitor ----------------
  // Each rising FrameValid consumes one expected frame; while FrameValid
  // stays high GRBSeq must not move.
  bit            fv_prev = 1'b0;
  logic [FW-1:0] seq_prev = '0;

  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (frame_valid && !fv_prev) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_frame: got %0h expected no new frame", grbseq);
          end else begin
            e = exp_q.pop_front();
            check("frame", grbseq, e[W-1:8]);
            check("step_count", FW'(step_count), FW'(e[7:0]));
          end
        end else if (frame_valid && fv_prev) begin
          check("frame_stable", grbseq, seq_prev);
        end
      end
      fv_prev  = frame_valid;
      seq_prev = grbseq;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_burst(input int n, input bit rand_mode, input logic [1:0] fixed_mode);
    logic [1:0] m;
    for (int k = 0; k < n; k++) begin
      m = rand_mode ? 2'($urandom_range(0, 3)) : fixed_mode;
      mode  = m;
      cycle = 1'b1;
      model_step(int'(m));
      @(negedge clk);
    end
    cycle = 1'b0;
    mode  = 2'($urandom_range(0, 3));
    exp_q.push_back(model_expect());
    @(negedge clk);
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain_timeout: got %0d pending frames expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic toggle_go();
    int k;
    go = 1'b1;
    m_running = !m_running;
    k = 0;
    while (running !== m_running && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("running_toggle", FW'(running), FW'(m_running));
    go = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic ignored_pulses(input int n);
    for (int k = 0; k < n; k++) begin
      cycle = 1'b1;
      mode  = 2'($urandom_range(0, 3));
      @(negedge clk);
      cycle = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    @(negedge clk);
    check("paused_frame", grbseq, model_frame());
    check("paused_count", FW'(step_count), FW'(m_count));
    check("paused_valid", FW'(frame_valid), FW'(1));
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check("rst_grbseq", grbseq, '0);
    check("rst_valid", FW'(frame_valid), FW'(0));
    check("rst_count", FW'(step_count), FW'(0));
    check("rst_running", FW'(running), FW'(0));
    exp_q.delete();
    model_reset();
    @(negedge clk);
    exp_q.push_back(model_expect());
    reset = 1'b0;
    wait_drain();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    reset = 1'b1;
    go    = 1'b0;
    cycle = 1'b0;
    mode  = 2'b00;
    repeat (3) @(negedge clk);

    // Reset frame: red, green, blue, yellow, cyan at 1/8 brightness
    apply_reset();
    check("reset_frame_literal", grbseq, 120'h001F00_1F0000_00001F_1F1F00_1F001F);

    // Start running and chase one place
    toggle_go();
    do_burst(1, 1'b0, 2'b01);
    wait_drain();
    check("chase_literal", grbseq, 120'h1F0000_00001F_1F1F00_1F001F_001F00);

    // Paused: Cycle pulses must change nothing
    toggle_go();
    ignored_pulses(4);
    toggle_go();

    // Fill: six single steps, wrapping position and colour
    for (int k = 0; k < 6; k++) begin
      do_burst(1, 1'b0, 2'b10);
      wait_drain();
    end
    check("fill6_literal", grbseq, 120'h1F0000_1F0000_000000_000000_000000);

    // Blink: blank then restore
    do_burst(1, 1'b0, 2'b11);
    wait_drain();
    check("blink_blank", grbseq, '0);
    do_burst(1, 1'b0, 2'b11);
    wait_drain();
    check("blink_restore", grbseq, 120'h1F0000_1F0000_000000_000000_000000);

    // Randomized bursts, with the occasional pause
    for (int t = 0; t < 40; t++) begin
      do_burst($urandom_range(1, 4), 1'b1, 2'b00);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 7) == 0) begin
        wait_drain();
        toggle_go();
        ignored_pulses($urandom_range(1, 3));
        toggle_go();
      end
    end
    wait_drain();

    // Go edge lands on the same clock as Cycle: the step still counts
    go = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cycle = 1'b1;
    mode  = 2'b01;
    model_step(1);
    exp_q.push_back(model_expect());
    @(negedge clk);
    cycle = 1'b0;
    m_running = 1'b0;
    check("coincident_running", FW'(running), FW'(0));
    go = 1'b0;
    repeat (3) @(negedge clk);
    wait_drain();
    toggle_go();

    // StepCount wraps through 255 back to 0 with back-to-back steps
    n = (m_count == 0) ? 256 : 256 - m_count;
    do_burst(n, 1'b0, 2'b00);
    wait_drain();
    check("count_wrap", FW'(step_count), FW'(0));

    // Reset in the middle of a step's pipeline drops it
    cycle = 1'b1;
    mode  = 2'b01;
    @(negedge clk);
    cycle = 1'b0;
    apply_reset();
    check("midreset_frame", grbseq, 120'h001F00_1F0000_00001F_1F1F00_1F001F);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Hard bound on run time
  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $display("%0d/%0d checks passed", passed, checks + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/frame_pattern_gen.md
FRAME_PATTERN_GEN -- requirements
Module: frame_pattern_gen

Interface
REQ-001 Parameter NUM_LEDS, 5: LEDs per frame; fixes GRBSeq width at 24*NUM_LEDS.
REQ-002 Parameter BRIGHT_SHIFT, 3: right-shift applied to every 8-bit colour channel; legal range 0..7.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 Go  input  1  asynchronous run/pause button; each rising edge toggles run state.
REQ-006 Cycle  input  1  one-clock pulse from the send controller meaning "frame shipped, next frame may be built".
REQ-007 mode  input  2  pattern select: 00 static, 01 chase, 10 fill, 11 blink; sampled only at a step.
REQ-008 GRBSeq  output  120  frame data; LED0 in [119:96], G,R,B order, MSB sent first.
REQ-009 FrameValid  output  1  high when GRBSeq matches the current pattern state.
REQ-010 StepCount  output  8  number of accepted steps, modulo 256.
REQ-011 Running  output  1  current run state.

Function
REQ-012 Go SHALL pass through a 2-flop synchroniser and rising-edge detector; each detected edge toggles Running.
REQ-013 A step SHALL be accepted on any clock where Cycle=1 and Running=1; Cycle with Running=0 SHALL be ignored.
REQ-014 If a Go edge and Cycle coincide, the step decision SHALL use Running before the toggle.
REQ-015 Each LED SHALL hold a 3-bit palette index: 0 off, 1 red, 2 green, 3 blue, 4 yellow, 5 cyan, 6 magenta, 7 white; full-scale channels are FF.
REQ-016 mode 00 step: indices unchanged.
REQ-017 mode 01 step: idx[i] <= idx[(i+1) mod NUM_LEDS], so colours move toward LED0.
REQ-018 mode 10 step: fillPos increments 0..NUM_LEDS-1 and wraps; idx[i] <= fillColor for i<=new fillPos, else 0. On wrap to 0, fillColor advances 1..7 and wraps 7->1.
REQ-019 mode 11 step: blank flag toggles; when blank=1, GRBSeq SHALL be all zero and indices are kept.
REQ-020 blank SHALL be forced to 0 at any step taken in a mode other than 11.
REQ-021 StepCount SHALL increment on every accepted step and wrap 255->0.
REQ-022 Pipeline: at the step edge, pattern state updates and FrameValid drops to 0. On the next edge, GRBSeq is registered from the new state and FrameValid returns to 1.
REQ-023 Back-to-back steps SHALL each be applied; FrameValid stays 0 until one clock after the last step.
REQ-024 Channel value SHALL be palette channel >> BRIGHT_SHIFT, zero-filled, 8 bits; no rounding.
REQ-025 GRBSeq SHALL change only on the edge that sets FrameValid; it is otherwise stable.

Reset
REQ-026 While reset is high: GRBSeq=0, FrameValid=0, StepCount=0, Running=0, blank=0, fillPos=0, fillColor=1, synchroniser flops=0, idx[i]=i+1 (1..5).
REQ-027 A pending-load flag SHALL be set by reset. The first edge after release registers GRBSeq from the reset indices and sets FrameValid=1.
REQ-028 Reset asserted mid-pipeline SHALL discard the in-flight step with no partial GRBSeq update.

Structure
REQ-029 Palette constants, mode encodings and NUM_LEDS default SHALL live in the shared include/package.
REQ-030 One sub-module, grb_palette, SHALL map index plus BRIGHT_SHIFT to a 24-bit GRB word; it is instantiated NUM_LEDS times.

Verification
REQ-031 Reset release, BRIGHT_SHIFT=3 -> after 1 clk FrameValid=1, GRBSeq=001F00_1F0000_00001F_1F1F00_1F001F.
REQ-032 Go edge, mode=01, one Cycle pulse -> FrameValid=0 for 1 clk, then GRBSeq=1F0000_00001F_1F1F00_1F001F_001F00, StepCount=1.
REQ-033 Running=0, Cycle pulses -> GRBSeq, StepCount, FrameValid unchanged.
REQ-034 mode=10, 6 steps -> fillPos sequence 1,2,3,4,0,1; at the 6th step LED0/LED1=green 1F0000, others 0.
REQ-035 mode=11, 2 steps -> first GRBSeq all zero, second restores the prior frame.
REQ-036 Go edge coincident with Cycle while running -> step applied, Running=0 afterwards; 256 steps -> StepCount wraps to 0.
